// File: rtl/ovc_txs_pkg.sv
// Shared definitions for the txs write-master arbiter: default widths,
// FSM state encoding and requester-slot helpers.
package ovc_txs_pkg;

  localparam int ADDR_W_DEF  = 23;
  localparam int BURST_W_DEF = 6;
  localparam int DATA_W_DEF  = 128;
  localparam int NUM_REQ     = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Maps a requester index to its bit in the per-requester vectors.
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/txs_burst_arbiter.sv
// Round-robin whole-burst arbiter sharing one Avalon-MM write master
// between two camera pipelines, with per-camera end-of-frame interrupts.
module txs_burst_arbiter
  import ovc_txs_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      c,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*BURST_W-1:0] req_burstcount,
  input  logic [NUM_REQ-1:0]        req_eof,
  output logic [NUM_REQ-1:0]        req_grant,
  input  logic [NUM_REQ*DATA_W-1:0] rd_data,
  output logic [NUM_REQ-1:0]        rd_pop,
  input  logic                      txs_waitrequest,
  output logic                      txs_write,
  output logic [ADDR_W-1:0]         txs_address,
  output logic [BURST_W-1:0]        txs_burstcount,
  output logic [DATA_W-1:0]         txs_writedata,
  output logic [NUM_REQ-1:0]        irq,
  input  logic [NUM_REQ-1:0]        irq_clear,
  output logic                      err,
  output logic                      busy
);

  state_e               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic                 src_q, src_d;
  logic                 eof_q, eof_d;
  logic                 first_q, first_d;
  logic                 err_q, err_d;
  logic [BURST_W-1:0]   beats_left_q, beats_left_d;
  logic [BURST_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [NUM_REQ-1:0]   irq_q, irq_d;
  logic [NUM_REQ-1:0]   zgrant_q, zgrant_d;
  logic [NUM_REQ-1:0]   irq_set;

  logic                 sel_src;
  logic [ADDR_W-1:0]    sel_addr;
  logic [BURST_W-1:0]   sel_count;
  logic                 accept;

  assign sel_src   = req_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign sel_addr  = sel_src ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
  assign sel_count = sel_src ? req_burstcount[BURST_W +: BURST_W]
                             : req_burstcount[0 +: BURST_W];
  assign accept    = (state_q == BURST) && !txs_waitrequest;

  // While a zero-length grant pulse is out, the requester has not yet had a
  // chance to withdraw it, so the stale request must not be sampled again.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    src_d        = src_q;
    eof_d        = eof_q;
    first_d      = 1'b0;
    err_d        = err_q;
    beats_left_d = beats_left_q;
    count_d      = count_q;
    addr_d       = addr_q;
    zgrant_d     = '0;
    irq_set      = '0;
    case (state_q)
      IDLE: begin
        if (enable && (|req_valid) && (zgrant_q == '0)) begin
          src_d        = sel_src;
          addr_d       = sel_addr;
          count_d      = sel_count;
          beats_left_d = sel_count;
          eof_d        = req_eof[sel_src];
          if (sel_count == '0) begin
            err_d    = 1'b1;
            zgrant_d = req_onehot(sel_src);
            ptr_d    = ~sel_src;
          end else begin
            state_d = BURST;
            first_d = 1'b1;
          end
        end
      end
      BURST: begin
        if (accept) begin
          beats_left_d = beats_left_q - BURST_W'(1);
          if (beats_left_q == BURST_W'(1)) begin
            state_d = IDLE;
            ptr_d   = ~src_q;
            if (eof_q) irq_set = req_onehot(src_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    irq_d = (irq_q & ~irq_clear) | irq_set;
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      src_q        <= 1'b0;
      eof_q        <= 1'b0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
      beats_left_q <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      irq_q        <= '0;
      zgrant_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      src_q        <= src_d;
      eof_q        <= eof_d;
      first_q      <= first_d;
      err_q        <= err_d;
      beats_left_q <= beats_left_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      irq_q        <= irq_d;
      zgrant_q     <= zgrant_d;
    end
  end

  assign busy           = (state_q == BURST);
  assign txs_write      = busy;
  assign txs_address    = busy ? addr_q : '0;
  assign txs_burstcount = busy ? count_q : '0;
  assign txs_writedata  = busy ? (src_q ? rd_data[DATA_W +: DATA_W] : rd_data[0 +: DATA_W])
                               : '0;
  assign rd_pop         = accept ? req_onehot(src_q) : '0;
  assign req_grant      = zgrant_q | ((busy && first_q) ? req_onehot(src_q) : '0);
  assign irq            = irq_q;
  assign err            = err_q;

endmodule

// File: tb/tb_txs_burst_arbiter.sv
// Directed, table-driven bench for txs_burst_arbiter with a show-ahead
// beat-source model per camera and hand-written multi-cycle sequences.
module tb_txs_burst_arbiter;

  localparam int AW = 23;
  localparam int BW = 6;
  localparam int DW = 128;

  logic            c;
  logic            rst_n;
  logic            enable;
  logic [1:0]      reqValid;
  logic [2*AW-1:0] reqAddr;
  logic [2*BW-1:0] reqBurstcount;
  logic [1:0]      reqEof;
  logic [1:0]      reqGrant;
  logic [2*DW-1:0] rdData;
  logic [1:0]      rdPop;
  logic            txsWaitrequest;
  logic            txsWrite;
  logic [AW-1:0]   txsAddress;
  logic [BW-1:0]   txsBurstcount;
  logic [DW-1:0]   txsWritedata;
  logic [1:0]      irq;
  logic [1:0]      irqClear;
  logic            err;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int headIdx[2];
  logic [AW-1:0] camAddr[2];

  txs_burst_arbiter dut (
    .c(c), .rst_n(rst_n), .enable(enable),
    .req_valid(reqValid), .req_addr(reqAddr), .req_burstcount(reqBurstcount),
    .req_eof(reqEof), .req_grant(reqGrant), .rd_data(rdData), .rd_pop(rdPop),
    .txs_waitrequest(txsWaitrequest), .txs_write(txsWrite),
    .txs_address(txsAddress), .txs_burstcount(txsBurstcount),
    .txs_writedata(txsWritedata), .irq(irq), .irq_clear(irqClear),
    .err(err), .busy(busy)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  function automatic logic [DW-1:0] mkData(input int n, input int idx);
    return {32'hD0D0_0000 + 32'(n), 32'h0, 32'h5A5A_5A5A, 32'(idx)};
  endfunction

  // Show-ahead requester beat sources; they share the DUT reset.
  always @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      headIdx[0] <= 0;
      headIdx[1] <= 0;
    end else begin
      if (rdPop[0]) headIdx[0] <= headIdx[0] + 1;
      if (rdPop[1]) headIdx[1] <= headIdx[1] + 1;
    end
  end

  always_comb rdData = {mkData(1, headIdx[1]), mkData(0, headIdx[0])};

  typedef struct {
    logic [1:0] valid;
    logic       en;
    logic       wr;
    logic [1:0] clr;
    logic [5:0] bc0;
    logic [5:0] bc1;
    logic [1:0] eof;
    logic       eWrite;
    logic [1:0] eGrant;
    logic [1:0] ePop;
    logic [1:0] eIrq;
    logic       eErr;
    int         eSrc;
    int         eIdx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] valid, input logic en, input logic wr,
                              input logic [1:0] clr, input logic [5:0] bc0,
                              input logic [5:0] bc1, input logic [1:0] eof,
                              input logic eWrite, input logic [1:0] eGrant,
                              input logic [1:0] ePop, input logic [1:0] eIrq,
                              input logic eErr, input int eSrc, input int eIdx);
    vec_t v;
    v.valid = valid; v.en = en; v.wr = wr; v.clr = clr;
    v.bc0 = bc0; v.bc1 = bc1; v.eof = eof;
    v.eWrite = eWrite; v.eGrant = eGrant; v.ePop = ePop;
    v.eIrq = eIrq; v.eErr = eErr; v.eSrc = eSrc; v.eIdx = eIdx;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs just after the falling edge, then settles.
  task automatic applyStimulus(input logic [1:0] valid, input logic en,
                               input logic wr, input logic [1:0] clr);
    @(negedge c);
    reqValid       = valid;
    enable         = en;
    txsWaitrequest = wr;
    irqClear       = clr;
    #1;
  endtask

  task automatic setBursts(input logic [5:0] bc0, input logic [5:0] bc1,
                           input logic [1:0] eof);
    reqBurstcount = {bc1, bc0};
    reqEof        = eof;
  endtask

  task automatic pulseReset();
    @(negedge c);
    rst_n = 1'b0;
    reqValid = 2'b00;
    @(negedge c);
    rst_n = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".write"}, txsWrite, '0);
    checkOutput({tag, ".addr"}, txsAddress, '0);
    checkOutput({tag, ".bc"}, txsBurstcount, '0);
    checkOutput({tag, ".data"}, txsWritedata, '0);
    checkOutput({tag, ".grant"}, reqGrant, '0);
    checkOutput({tag, ".pop"}, rdPop, '0);
    checkOutput({tag, ".irq"}, irq, '0);
    checkOutput({tag, ".err"}, err, '0);
    checkOutput({tag, ".busy"}, busy, '0);
  endtask

  initial begin
    int lastGrant;
    int grantsSeen;
    logic [1:0] expGrant;

    camAddr[0] = 23'h000100;
    camAddr[1] = 23'h000200;
    rst_n = 1'b0;
    enable = 1'b0;
    reqValid = 2'b00;
    reqAddr = {camAddr[1], camAddr[0]};
    reqBurstcount = '0;
    reqEof = 2'b00;
    txsWaitrequest = 1'b0;
    irqClear = 2'b00;

    repeat (2) @(negedge c);
    #1;
    checkAllZero("reset");
    @(negedge c);
    rst_n = 1'b1;

    // valid en wr clr bc0 bc1 eof | write grant pop irq err src idx
    // Single cam 0 burst of 4, no back-pressure.
    vecs.push_back(mk(2'b01,1,0,2'b00,4,2,2'b00, 0,2'b00,2'b00,2'b00,0,0,0));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 1,2'b01,2'b01,2'b00,0,0,0));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 1,2'b00,2'b01,2'b00,0,0,1));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 1,2'b00,2'b01,2'b00,0,0,2));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 1,2'b00,2'b01,2'b00,0,0,3));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 0,2'b00,2'b00,2'b00,0,0,0));
    // Same burst, waitrequest high for three cycles on the second beat.
    vecs.push_back(mk(2'b01,1,0,2'b00,4,2,2'b00, 0,2'b00,2'b00,2'b00,0,0,0));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 1,2'b01,2'b01,2'b00,0,0,4));
    vecs.push_back(mk(2'b00,1,1,2'b00,4,2,2'b00, 1,2'b00,2'b00,2'b00,0,0,5));
    vecs.push_back(mk(2'b00,1,1,2'b00,4,2,2'b00, 1,2'b00,2'b00,2'b00,0,0,5));
    vecs.push_back(mk(2'b00,1,1,2'b00,4,2,2'b00, 1,2'b00,2'b00,2'b00,0,0,5));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 1,2'b00,2'b01,2'b00,0,0,5));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 1,2'b00,2'b01,2'b00,0,0,6));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 1,2'b00,2'b01,2'b00,0,0,7));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 0,2'b00,2'b00,2'b00,0,0,0));
    // Cam 1 end-of-frame burst, then a second one with a coincident clear.
    vecs.push_back(mk(2'b10,1,0,2'b00,4,2,2'b10, 0,2'b00,2'b00,2'b00,0,1,0));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b10, 1,2'b10,2'b10,2'b00,0,1,0));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b10, 1,2'b00,2'b10,2'b00,0,1,1));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b10, 0,2'b00,2'b00,2'b10,0,1,0));
    vecs.push_back(mk(2'b10,1,0,2'b00,4,2,2'b10, 0,2'b00,2'b00,2'b10,0,1,0));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b10, 1,2'b10,2'b10,2'b10,0,1,2));
    vecs.push_back(mk(2'b00,1,0,2'b10,4,2,2'b10, 1,2'b00,2'b10,2'b10,0,1,3));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b10, 0,2'b00,2'b00,2'b10,0,1,0));
    vecs.push_back(mk(2'b00,1,0,2'b10,4,2,2'b10, 0,2'b00,2'b00,2'b10,0,1,0));
    vecs.push_back(mk(2'b00,1,0,2'b00,4,2,2'b00, 0,2'b00,2'b00,2'b00,0,1,0));
    // Enable dropped right after the grant: burst completes, no new grant.
    vecs.push_back(mk(2'b01,1,0,2'b00,4,2,2'b00, 0,2'b00,2'b00,2'b00,0,0,0));
    vecs.push_back(mk(2'b01,0,0,2'b00,4,2,2'b00, 1,2'b01,2'b01,2'b00,0,0,8));
    vecs.push_back(mk(2'b01,0,0,2'b00,4,2,2'b00, 1,2'b00,2'b01,2'b00,0,0,9));
    vecs.push_back(mk(2'b01,0,0,2'b00,4,2,2'b00, 1,2'b00,2'b01,2'b00,0,0,10));
    vecs.push_back(mk(2'b01,0,0,2'b00,4,2,2'b00, 1,2'b00,2'b01,2'b00,0,0,11));
    vecs.push_back(mk(2'b01,0,0,2'b00,4,2,2'b00, 0,2'b00,2'b00,2'b00,0,0,0));
    vecs.push_back(mk(2'b01,0,0,2'b00,4,2,2'b00, 0,2'b00,2'b00,2'b00,0,0,0));
    vecs.push_back(mk(2'b00,0,0,2'b00,4,2,2'b00, 0,2'b00,2'b00,2'b00,0,0,0));
    // Zero-length burst: error and grant pulse, never a write.
    vecs.push_back(mk(2'b01,1,0,2'b00,0,2,2'b00, 0,2'b00,2'b00,2'b00,0,0,0));
    vecs.push_back(mk(2'b00,1,0,2'b00,0,2,2'b00, 0,2'b01,2'b00,2'b00,1,0,0));
    vecs.push_back(mk(2'b00,1,0,2'b00,0,2,2'b00, 0,2'b00,2'b00,2'b00,1,0,0));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      setBursts(v.bc0, v.bc1, v.eof);
      applyStimulus(v.valid, v.en, v.wr, v.clr);
      checkOutput($sformatf("row%0d.write", i), txsWrite, v.eWrite);
      checkOutput($sformatf("row%0d.busy", i), busy, v.eWrite);
      checkOutput($sformatf("row%0d.grant", i), reqGrant, v.eGrant);
      checkOutput($sformatf("row%0d.pop", i), rdPop, v.ePop);
      checkOutput($sformatf("row%0d.irq", i), irq, v.eIrq);
      checkOutput($sformatf("row%0d.err", i), err, v.eErr);
      if (v.eWrite) begin
        checkOutput($sformatf("row%0d.addr", i), txsAddress, camAddr[v.eSrc]);
        checkOutput($sformatf("row%0d.bc", i), txsBurstcount,
                    (v.eSrc == 1) ? v.bc1 : v.bc0);
        checkOutput($sformatf("row%0d.data", i), txsWritedata, mkData(v.eSrc, v.eIdx));
      end
    end

    // Fairness: both always requesting 8-beat bursts from ptr=0.
    pulseReset();
    setBursts(6'd8, 6'd8, 2'b00);
    lastGrant = -1;
    grantsSeen = 0;
    expGrant = 2'b01;
    for (int cyc = 0; cyc < 60 && grantsSeen < 4; cyc++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 2'b00);
      if (reqGrant != 2'b00) begin
        checkOutput($sformatf("fair.grant%0d", grantsSeen), reqGrant, expGrant);
        if (lastGrant >= 0)
          checkOutput($sformatf("fair.gap%0d", grantsSeen), 128'(cyc - lastGrant), 128'(9));
        lastGrant = cyc;
        grantsSeen++;
        expGrant = ~expGrant;
      end
    end
    checkOutput("fair.grantcount", 128'(grantsSeen), 128'(4));

    // Reset asserted during the third beat of an 8-beat burst.
    pulseReset();
    setBursts(6'd8, 6'd2, 2'b00);
    applyStimulus(2'b01, 1'b1, 1'b0, 2'b00);
    applyStimulus(2'b00, 1'b1, 1'b0, 2'b00);
    applyStimulus(2'b00, 1'b1, 1'b0, 2'b00);
    applyStimulus(2'b00, 1'b1, 1'b0, 2'b00);
    checkOutput("midrst.before", txsWrite, 1'b1);
    checkOutput("midrst.beat3", txsWritedata, mkData(0, 2));
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    @(negedge c);
    rst_n = 1'b1;
    setBursts(6'd2, 6'd2, 2'b00);
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b00);
    checkOutput("after.idle", txsWrite, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0, 2'b00);
    checkOutput("after.grant", reqGrant, 2'b01);
    checkOutput("after.addr", txsAddress, camAddr[0]);
    checkOutput("after.data", txsWritedata, mkData(0, 0));
    applyStimulus(2'b00, 1'b1, 1'b0, 2'b00);
    checkOutput("after.beat2", rdPop, 2'b01);
    applyStimulus(2'b00, 1'b1, 1'b0, 2'b00);
    checkOutput("after.done", txsWrite, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
